// File: rtl/frame_scanout.sv
// frame_scanout: double-buffered 1-bit framebuffer with video timing and a bank swap at vblank start
module frame_scanout #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int HOR_FRONT_PORCH   = 16,
    parameter int HOR_SYNC          = 96,
    parameter int HOR_BACK_PORCH    = 48,
    parameter int VER_FRONT_PORCH   = 10,
    parameter int VER_SYNC          = 2,
    parameter int VER_BACK_PORCH    = 33,
    parameter bit SYNC_ACTIVE_HIGH  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pix_ce,
    input  logic render_done,
    input  logic wr_en,
    input  logic [$clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)-1:0] wr_addr,
    input  logic wr_data,
    output logic swap,
    output logic hsync,
    output logic vsync,
    output logic de,
    output logic pixel
);
    localparam int H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC + HOR_BACK_PORCH;
    localparam int V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC + VER_BACK_PORCH;
    localparam int DEPTH = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_ACT  = HW'(HOR_ACTIVE_PIXELS);
    localparam logic [HW-1:0] H_SS   = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
    localparam logic [HW-1:0] H_SE   = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC - 1);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(VER_ACTIVE_PIXELS);
    localparam logic [VW-1:0] V_SS   = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
    localparam logic [VW-1:0] V_SE   = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic {SCANNING, SWAPPED} state_t;

    state_t          state;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            front_bank;
    logic            bank0 [DEPTH];
    logic            bank1 [DEPTH];
    logic            h_last, v_last, active, hs_act, vs_act, wr_ok;
    logic            vblank_start, frame_start;
    logic [AW-1:0]   rd_addr;

    // Stage 0: decode the current counter position
    always_comb begin
        h_last       = h_cnt == H_LAST;
        v_last       = v_cnt == V_LAST;
        active       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_act       = (h_cnt >= H_SS) && (h_cnt <= H_SE);
        vs_act       = (v_cnt >= V_SS) && (v_cnt <= V_SE);
        vblank_start = (h_cnt == '0) && (v_cnt == V_ACT);
        frame_start  = (h_cnt == '0) && (v_cnt == '0);
        rd_addr      = active ? AW'(32'(v_cnt) * 32'(HOR_ACTIVE_PIXELS) + 32'(h_cnt)) : '0;
        wr_ok        = wr_en && ({1'b0, wr_addr} < DEPTH_W);
    end

    // Renderer writes always land in the bank that is not being scanned out
    always_ff @(posedge clk) begin
        if (wr_ok && front_bank) bank0[wr_addr] <= wr_data;
        if (wr_ok && !front_bank) bank1[wr_addr] <= wr_data;
    end

    // Pixel and line counters advance once per pix_ce
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end
    end

    // Stage 1: register memory data and timing so all outputs share one cycle of latency
    always_ff @(posedge clk) begin
        if (!rst) begin
            de    <= 1'b0;
            pixel <= 1'b0;
            hsync <= !SYNC_ACTIVE_HIGH;
            vsync <= !SYNC_ACTIVE_HIGH;
        end else if (pix_ce) begin
            de    <= active;
            pixel <= active && (front_bank ? bank1[rd_addr] : bank0[rd_addr]);
            hsync <= hs_act == SYNC_ACTIVE_HIGH;
            vsync <= vs_act == SYNC_ACTIVE_HIGH;
        end
    end

    // Swap banks only at vblank start; hold swap through the whole vblank
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= SCANNING;
            front_bank <= 1'b0;
            swap       <= 1'b0;
        end else if (pix_ce) begin
            if (state == SCANNING) begin
                if (vblank_start && render_done) begin
                    front_bank <= !front_bank;
                    swap       <= 1'b1;
                    state      <= SWAPPED;
                end
            end else if (frame_start) begin
                swap  <= 1'b0;
                state <= SCANNING;
            end
        end
    end
endmodule

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout: directed frames on a 12x7 timing grid checking sync, de, pixel and swap
module tb_frame_scanout;
    localparam int HA = 8;
    localparam int VA = 4;
    localparam int HT = 12;
    localparam int VT = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pix_ce = 1'b0;
    logic       render_done = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic       wr_data = 1'b0;
    logic       swap, hsync, vsync, de, pixel;
    int         n_chk = 0;
    int         n_pass = 0;
    bit         p_rec [32];

    frame_scanout #(
        .HOR_ACTIVE_PIXELS(HA), .VER_ACTIVE_PIXELS(VA),
        .HOR_FRONT_PORCH(1), .HOR_SYNC(2), .HOR_BACK_PORCH(1),
        .VER_FRONT_PORCH(1), .VER_SYNC(1), .VER_BACK_PORCH(1)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .render_done(render_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap(swap), .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %b expected %b", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input bit d);
        wr_en = 1'b1;
        wr_addr = 5'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // mode 0: record pixels, 1: repeat of recorded frame, 2: checkerboard, 3: addr[1] pattern
    task automatic check_out(input int h, input int v, input int mode, input bit rd);
        int a;
        bit act;
        a = v * HA + h;
        act = (h < HA) && (v < VA);
        chk("de", de, act);
        chk("hsync", hsync, !(h >= 9 && h <= 10));
        chk("vsync", vsync, v != 5);
        chk("swap", swap, rd && v >= 4);
        if (!act) chk("pix_blank", pixel, 1'b0);
        else if (mode == 0) p_rec[a] = pixel;
        else if (mode == 1) chk("pix_repeat", pixel, p_rec[a]);
        else if (mode == 2) chk("pix_checker", pixel, ((a % 2) == 1) != (((a / 8) % 2) == 1));
        else chk("pix_bank0", pixel, ((a / 2) % 2) == 1);
    endtask

    task automatic run_frame(input int mode, input bit rd, input bit freeze, input bit rst_at);
        render_done = rd;
        for (int v = 0; v < VT; v++)
            for (int h = 0; h < HT; h++) begin
                if (freeze && v == 1 && h == 3) begin
                    pix_ce = 1'b0;
                    repeat (5) begin
                        tick();
                        check_out(2, 1, mode, rd);
                    end
                    pix_ce = 1'b1;
                end
                if (rst_at && v == 5 && h == 3) begin
                    rst = 1'b0;
                    tick();
                    chk("rst_swap", swap, 1'b0);
                    chk("rst_de", de, 1'b0);
                    chk("rst_pixel", pixel, 1'b0);
                    chk("rst_hsync", hsync, 1'b1);
                    chk("rst_vsync", vsync, 1'b1);
                    rst = 1'b1;
                    return;
                end
                tick();
                check_out(h, v, mode, rd);
            end
    endtask

    initial begin
        rst = 1'b0;
        pix_ce = 1'b1;
        tick();
        tick();
        chk("reset_swap", swap, 1'b0);
        chk("reset_de", de, 1'b0);
        chk("reset_pixel", pixel, 1'b0);
        chk("reset_hsync", hsync, 1'b1);
        chk("reset_vsync", vsync, 1'b1);
        rst = 1'b1;
        pix_ce = 1'b0;
        for (int a = 0; a < 32; a++) wr(a, ((a % 2) == 1) != (((a / 8) % 2) == 1));
        chk("hold_de", de, 1'b0);
        chk("hold_hsync", hsync, 1'b1);
        pix_ce = 1'b1;
        run_frame(0, 1'b0, 1'b0, 1'b0);
        run_frame(1, 1'b1, 1'b0, 1'b0);
        run_frame(2, 1'b0, 1'b1, 1'b0);
        pix_ce = 1'b0;
        for (int a = 0; a < 32; a++) wr(a, ((a / 2) % 2) == 1);
        pix_ce = 1'b1;
        run_frame(2, 1'b1, 1'b0, 1'b0);
        run_frame(3, 1'b1, 1'b0, 1'b1);
        run_frame(3, 1'b0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
